// File: rtl/fir_tap_sequencer.sv
// Sample delay line and frame sequencer feeding the symmetric-FIR pre-adder DSP chain.
// One accepted sample launches STAGES counter frames; the DSP stages latch on counter == STROBE.
module fir_tap_sequencer #(
  parameter int unsigned TAPS   = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned STROBE = 12,
  parameter int unsigned NPAIR  = TAPS / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [7:0]           sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [8*NPAIR-1:0]   x1_bus,
  output logic [8*NPAIR-1:0]   x2_bus,
  output logic [3:0]           counter,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = 4;
  localparam int unsigned FW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CW-1:0] STROBE_V   = CW'(STROBE);
  localparam logic [FW-1:0] LAST_FRAME = FW'(STAGES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         counter_q, counter_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  done_q, done_d;
  logic [TAPS-1:0][7:0]  tap_q, tap_d;

  // State, counter, frame index, done pulse and delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
      tap_q     <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      tap_q     <= tap_d;
    end
  end

  // Next-state: clear wins over accept and over an active run
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    tap_d     = tap_q;
    if (clear) begin
      state_d   = IDLE;
      counter_d = '0;
      frame_d   = '0;
      tap_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          counter_d = '0;
          frame_d   = '0;
          if (sample_valid) begin
            tap_d   = {tap_q[TAPS-2:0], sample_in};
            state_d = RUN;
          end
        end
        RUN: begin
          if (counter_q != STROBE_V) begin
            counter_d = counter_q + CW'(1);
          end else if (frame_q < LAST_FRAME) begin
            frame_d   = frame_q + FW'(1);
            counter_d = '0;
          end else begin
            state_d   = IDLE;
            counter_d = '0;
            frame_d   = '0;
            done_d    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign busy         = (state_q == RUN);
  assign counter      = counter_q;
  assign done         = done_q;

  // Mirrored tap pairs: pair k carries tap[k] and tap[TAPS-1-k]
  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    assign x1_bus[8*k +: 8] = tap_q[k];
    assign x2_bus[8*k +: 8] = tap_q[TAPS-1-k];
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: vector table, directed corner sequences,
// accept-triggered scoreboard for tap buses and a strobe/idle monitor.
module tb_fir_tap_sequencer;

  localparam int unsigned BW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [7:0]    sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [BW-1:0] x1_bus;
  logic [BW-1:0] x2_bus;
  logic [3:0]    counter;
  logic          busy;
  logic          done;

  fir_tap_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .x1_bus       (x1_bus),
    .x2_bus       (x2_bus),
    .counter      (counter),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] x1;
    logic [BW-1:0] x2;
  } exp_t;

  typedef struct packed {
    logic [7:0]    sample;
    logic [BW-1:0] x1;
    logic [BW-1:0] x2;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic acc_ev   = 1'b0;
  logic clr_ev   = 1'b0;
  int   run_strobes = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a sample, hold valid until accepted, return in the first run cycle
  task automatic send(input logic [7:0] s, input logic [BW-1:0] ex1, input logic [BW-1:0] ex2);
    logic got;
    got = 1'b0;
    sample_in    = s;
    sample_valid = 1'b1;
    sb_q.push_back('{x1: ex1, x2: ex2});
    for (int n = 0; n < 200; n++) begin
      got = sample_ready;
      tick();
      if (got) break;
    end
    sample_valid = 1'b0;
    chk("accept_timeout", BW'(got), BW'(1));
  endtask

  // Walk a run from cycle 0 through the done cycle (k = 39); optionally inject 0xAA at inj
  task automatic run_check(input int inj, input logic [BW-1:0] ex1, input logic [BW-1:0] ex2);
    for (int k = 0; k <= 39; k++) begin
      if (k > 0) tick();
      if (k == inj) begin
        sample_in    = 8'hAA;
        sample_valid = 1'b1;
        sb_q.push_back('{x1: 32'h070811AA, x2: 32'h06050403});
      end
      chk("run_counter", BW'(counter), (k < 39) ? BW'(k % 13) : BW'(0));
      chk("run_busy",    BW'(busy),    BW'(k < 39));
      chk("run_ready",   BW'(sample_ready), BW'(k >= 39));
      chk("run_done",    BW'(done),    BW'(k == 39));
      chk("run_x1",      x1_bus, ex1);
      chk("run_x2",      x2_bus, ex2);
    end
  endtask

  initial begin
    vec_t vecs[8];
    exp_t e;

    vecs[0] = '{sample: 8'd1, x1: 32'h00000001, x2: 32'h00000000};
    vecs[1] = '{sample: 8'd2, x1: 32'h00000102, x2: 32'h00000000};
    vecs[2] = '{sample: 8'd3, x1: 32'h00010203, x2: 32'h00000000};
    vecs[3] = '{sample: 8'd4, x1: 32'h01020304, x2: 32'h00000000};
    vecs[4] = '{sample: 8'd5, x1: 32'h02030405, x2: 32'h01000000};
    vecs[5] = '{sample: 8'd6, x1: 32'h03040506, x2: 32'h02010000};
    vecs[6] = '{sample: 8'd7, x1: 32'h04050607, x2: 32'h03020100};
    vecs[7] = '{sample: 8'd8, x1: 32'h05060708, x2: 32'h04030201};

    rst          = 1'b1;
    clear        = 1'b0;
    sample_in    = 8'h00;
    sample_valid = 1'b0;

    fork
      forever begin
        @(posedge clk);
        acc_ev = sample_valid && sample_ready && !clear && !rst;
        clr_ev = clear;
      end
      forever begin
        @(negedge clk);
        if (rst || clr_ev) run_strobes = 0;
        if (!rst) begin
          if (acc_ev) begin
            run_strobes = 0;
            if (sb_q.size() == 0) begin
              chk("unexpected_accept", BW'(1), BW'(0));
            end else begin
              e = sb_q.pop_front();
              chk("sb_x1", x1_bus, e.x1);
              chk("sb_x2", x2_bus, e.x2);
              chk("sb_first_counter", BW'(counter), BW'(0));
            end
          end
          chk("idle_no_strobe", BW'(counter == 4'd12 && !busy), BW'(0));
          if (busy && counter == 4'd12) run_strobes++;
          if (done) begin
            chk("strobes_per_run", BW'(run_strobes), BW'(3));
            run_strobes = 0;
          end
        end
      end
    join_none

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready",   BW'(sample_ready), BW'(1));
    chk("rst_busy",    BW'(busy),    BW'(0));
    chk("rst_done",    BW'(done),    BW'(0));
    chk("rst_counter", BW'(counter), BW'(0));
    chk("rst_x1",      x1_bus,       BW'(0));
    chk("rst_x2",      x2_bus,       BW'(0));

    // Single sample run
    send(8'h05, 32'h00000005, 32'h00000000);
    run_check(-1, 32'h00000005, 32'h00000000);
    tick();
    chk("done_one_cycle", BW'(done), BW'(0));

    // Flush, then back-to-back table samples
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_x1", x1_bus, BW'(0));
    chk("clear_x2", x2_bus, BW'(0));
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sample, vecs[i].x1, vecs[i].x2);
      chk("vec_x1", x1_bus, vecs[i].x1);
      chk("vec_x2", x2_bus, vecs[i].x2);
    end
    run_check(-1, 32'h05060708, 32'h04030201);
    tick();

    // Valid during a run is ignored, then accepted in the done cycle
    send(8'h11, 32'h06070811, 32'h05040302);
    run_check(10, 32'h06070811, 32'h05040302);
    tick();
    sample_valid = 1'b0;
    run_check(-1, 32'h070811AA, 32'h06050403);
    tick();

    // Clear at counter 7 of the second frame
    send(8'h22, 32'h0811AA22, 32'h07060504);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("pre_clear_counter", BW'(counter), BW'(k % 13));
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_x1",      x1_bus,       BW'(0));
    chk("clr_x2",      x2_bus,       BW'(0));
    chk("clr_counter", BW'(counter), BW'(0));
    chk("clr_ready",   BW'(sample_ready), BW'(1));
    chk("clr_busy",    BW'(busy),    BW'(0));
    for (int k = 0; k < 45; k++) begin
      tick();
      chk("clr_no_done", BW'(done || counter != 4'd0), BW'(0));
    end
    sample_in    = 8'h33;
    sample_valid = 1'b1;
    clear        = 1'b1;
    tick();
    clear        = 1'b0;
    sample_valid = 1'b0;
    chk("clrv_x1",    x1_bus, BW'(0));
    chk("clrv_x2",    x2_bus, BW'(0));
    chk("clrv_ready", BW'(sample_ready), BW'(1));
    chk("clrv_busy",  BW'(busy), BW'(0));

    // Async reset at the first strobe
    send(8'h44, 32'h00000044, 32'h00000000);
    for (int k = 1; k <= 12; k++) tick();
    chk("pre_rst_counter", BW'(counter), BW'(12));
    rst = 1'b1;
    #1;
    chk("arst_counter", BW'(counter), BW'(0));
    chk("arst_busy",    BW'(busy),    BW'(0));
    chk("arst_ready",   BW'(sample_ready), BW'(1));
    chk("arst_done",    BW'(done),    BW'(0));
    chk("arst_x1",      x1_bus,       BW'(0));
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("post_rst_quiet", BW'(counter != 4'd0 || busy || done), BW'(0));
    end
    send(8'h55, 32'h00000055, 32'h00000000);
    run_check(-1, 32'h00000055, 32'h00000000);
    tick();
    chk("final_done_low", BW'(done), BW'(0));
    chk("sb_drained", BW'(sb_q.size()), BW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
